// File: rtl/caf_pkg.sv
// Shared definitions for the CAF peak scheduler: FSM state type and width helpers.
package caf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT_RES,
    OUT
  } caf_state_e;

  // Minimum counter width able to index n items (at least one bit).
  function automatic int unsigned caf_min_bits(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/caf_peak_tracker.sv
// Holds the best (max, index, bin) seen so far; strict greater-than keeps the earliest on ties.
module caf_peak_tracker #(
  parameter int unsigned max_bits   = 25,
  parameter int unsigned index_bits = 8,
  parameter int unsigned freq_bits  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  logic [max_bits-1:0]   in_max,
  input  logic [index_bits-1:0] in_index,
  input  logic [freq_bits-1:0]  in_bin,
  output logic [max_bits-1:0]   best_max,
  output logic [index_bits-1:0] best_index,
  output logic [freq_bits-1:0]  best_bin
);

  logic best_valid;
  logic take;

  assign take = !best_valid || (in_max > best_max);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      best_valid <= 1'b0;
      best_max   <= '0;
      best_index <= '0;
      best_bin   <= '0;
    end else if (load && take) begin
      best_valid <= 1'b1;
      best_max   <= in_max;
      best_index <= in_index;
      best_bin   <= in_bin;
    end
  end

endmodule

// File: rtl/caf_peak_scheduler.sv
// Sequences arg_max over num_bins frames of frame_len samples and reports the global peak
// of the whole CAF search as a single AXI-Stream result.
module caf_peak_scheduler
  import caf_pkg::*;
#(
  parameter int unsigned i_bits       = 12,
  parameter int unsigned q_bits       = 12,
  parameter int unsigned out_max_bits = 25,
  parameter int unsigned index_bits   = 8,
  parameter int unsigned freq_bits    = 4,
  parameter int unsigned num_bins     = 16,
  parameter int unsigned frame_len    = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [i_bits-1:0]       s_axis_xi,
  input  logic [q_bits-1:0]       s_axis_xq,
  output logic                    am_tvalid,
  input  logic                    am_tready,
  output logic [i_bits-1:0]       am_xi,
  output logic [q_bits-1:0]       am_xq,
  output logic                    am_tlast,
  input  logic                    am_res_tvalid,
  output logic                    am_res_tready,
  input  logic [out_max_bits-1:0] am_res_max,
  input  logic [index_bits-1:0]   am_res_index,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [out_max_bits-1:0] peak_max,
  output logic [index_bits-1:0]   peak_index,
  output logic [freq_bits-1:0]    peak_bin
);

  if (caf_min_bits(frame_len) > index_bits) begin : g_bad_index_bits
    $error("index_bits too narrow for frame_len");
  end
  if (caf_min_bits(num_bins) > freq_bits) begin : g_bad_freq_bits
    $error("freq_bits too narrow for num_bins");
  end

  localparam logic [index_bits-1:0] LAST_SAMPLE = index_bits'(frame_len - 1);
  localparam logic [freq_bits-1:0]  LAST_BIN    = freq_bits'(num_bins - 1);

  caf_state_e              state, state_nxt;
  logic [index_bits-1:0]   sample_cnt;
  logic [freq_bits-1:0]    bin_cnt;
  logic                    xfer;
  logic                    res_fire;
  logic                    search_start;

  assign am_xi        = s_axis_xi;
  assign am_xq        = s_axis_xq;
  assign am_tlast     = (sample_cnt == LAST_SAMPLE);
  assign xfer         = am_tvalid && am_tready;
  assign res_fire     = am_res_tvalid && am_res_tready;
  assign search_start = (state == IDLE) && start;

  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    am_tvalid     = 1'b0;
    s_axis_tready = 1'b0;
    am_res_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = STREAM;
      end
      STREAM: begin
        busy          = 1'b1;
        am_tvalid     = s_axis_tvalid;
        s_axis_tready = am_tready;
        if (s_axis_tvalid && am_tready && am_tlast) state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        busy          = 1'b1;
        am_res_tready = 1'b1;
        if (am_res_tvalid) state_nxt = (bin_cnt == LAST_BIN) ? OUT : STREAM;
      end
      OUT: begin
        busy          = 1'b1;
        m_axis_tvalid = 1'b1;
        if (m_axis_tready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sample_cnt <= '0;
      bin_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (search_start) begin
        sample_cnt <= '0;
        bin_cnt    <= '0;
      end
      if (xfer) sample_cnt <= am_tlast ? '0 : sample_cnt + index_bits'(1);
      if (res_fire && (bin_cnt != LAST_BIN)) bin_cnt <= bin_cnt + freq_bits'(1);
    end
  end

  caf_peak_tracker #(
    .max_bits   (out_max_bits),
    .index_bits (index_bits),
    .freq_bits  (freq_bits)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .clear      (search_start),
    .load       (res_fire),
    .in_max     (am_res_max),
    .in_index   (am_res_index),
    .in_bin     (bin_cnt),
    .best_max   (peak_max),
    .best_index (peak_index),
    .best_bin   (peak_bin)
  );

endmodule

// File: tb/tb_caf_peak_scheduler.sv
// Scoreboard bench for caf_peak_scheduler: a stub arg_max replays per-bin result tables and
// the expected global peak is queued at each accepted start.
module tb_caf_peak_scheduler;

  localparam int NB = 4;
  localparam int FL = 8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, busy;
  logic        s_axis_tvalid, s_axis_tready;
  logic [11:0] s_axis_xi, s_axis_xq;
  logic        am_tvalid, am_tready, am_tlast;
  logic [11:0] am_xi, am_xq;
  logic        am_res_tvalid, am_res_tready;
  logic [24:0] am_res_max;
  logic [7:0]  am_res_index;
  logic        m_axis_tvalid, m_axis_tready;
  logic [24:0] peak_max;
  logic [7:0]  peak_index;
  logic [3:0]  peak_bin;

  caf_peak_scheduler #(.num_bins(NB), .frame_len(FL)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_xi(s_axis_xi), .s_axis_xq(s_axis_xq),
    .am_tvalid(am_tvalid), .am_tready(am_tready), .am_xi(am_xi), .am_xq(am_xq),
    .am_tlast(am_tlast),
    .am_res_tvalid(am_res_tvalid), .am_res_tready(am_res_tready),
    .am_res_max(am_res_max), .am_res_index(am_res_index),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .peak_max(peak_max), .peak_index(peak_index), .peak_bin(peak_bin)
  );

  // Second instance for the single-bin, single-sample corner.
  logic        d1_start, d1_busy, d1_s_tvalid, d1_s_tready;
  logic [11:0] d1_s_xi, d1_s_xq, d1_am_xi, d1_am_xq;
  logic        d1_am_tvalid, d1_am_tready, d1_am_tlast;
  logic        d1_res_tvalid, d1_res_tready;
  logic [24:0] d1_res_max, d1_peak_max;
  logic [7:0]  d1_res_index, d1_peak_index;
  logic        d1_m_tvalid, d1_m_tready;
  logic [3:0]  d1_peak_bin;

  caf_peak_scheduler #(.num_bins(1), .frame_len(1)) dut1 (
    .clk(clk), .rst(rst), .start(d1_start), .busy(d1_busy),
    .s_axis_tvalid(d1_s_tvalid), .s_axis_tready(d1_s_tready),
    .s_axis_xi(d1_s_xi), .s_axis_xq(d1_s_xq),
    .am_tvalid(d1_am_tvalid), .am_tready(d1_am_tready), .am_xi(d1_am_xi), .am_xq(d1_am_xq),
    .am_tlast(d1_am_tlast),
    .am_res_tvalid(d1_res_tvalid), .am_res_tready(d1_res_tready),
    .am_res_max(d1_res_max), .am_res_index(d1_res_index),
    .m_axis_tvalid(d1_m_tvalid), .m_axis_tready(d1_m_tready),
    .peak_max(d1_peak_max), .peak_index(d1_peak_index), .peak_bin(d1_peak_bin)
  );

  typedef struct {
    logic [24:0] mx;
    logic [7:0]  ix;
    logic [3:0]  bn;
  } exp_t;

  exp_t        sb[$];
  exp_t        last_exp;
  logic [24:0] tab_max [NB];
  logic [7:0]  tab_idx [NB];

  int checks = 0;
  int failures = 0;

  // Bench-side model of where the scheduler should be.
  bit start_req, rst_req, rnd_ready, poke_start;
  bit busy_exp, wait_flag, out_flag, res_pending, aborted;
  int res_wait, res_delay, res_frame, hold_cnt, xfer_cnt, rst_after, done_cnt;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t golden();
    exp_t e;
    bit   bv = 1'b0;
    e = '{25'd0, 8'd0, 4'd0};
    for (int b = 0; b < NB; b++) begin
      if (!bv || tab_max[b] > e.mx) begin
        e  = '{tab_max[b], tab_idx[b], 4'(b)};
        bv = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic step();
    bit   was_busy, exp_last;
    exp_t e;
    @(negedge clk);
    start     = start_req;  start_req = 1'b0;
    rst       = rst_req;    rst_req   = 1'b0;
    am_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_xi = 12'($urandom);
    s_axis_xq = 12'($urandom);
    am_res_tvalid = res_pending && (res_wait == 0);
    am_res_max    = am_res_tvalid ? tab_max[res_frame % NB] : 25'd0;
    am_res_index  = am_res_tvalid ? tab_idx[res_frame % NB] : 8'd0;
    if (res_pending && res_wait > 0) res_wait--;
    m_axis_tready = !(out_flag && hold_cnt > 0);
    if (out_flag && hold_cnt > 0) hold_cnt--;
    #1;
    chk_eq("busy", busy, busy_exp);
    chk_eq("m_tvalid", m_axis_tvalid, out_flag);
    chk_eq("res_tready", am_res_tready, wait_flag);
    if (!(busy_exp && !wait_flag && !out_flag)) begin
      chk_eq("stall_tready", s_axis_tready, 0);
      chk_eq("stall_tvalid", am_tvalid, 0);
    end
    if (out_flag && sb.size() > 0) begin
      chk_eq("hold_max", peak_max, sb[0].mx);
      chk_eq("hold_index", peak_index, sb[0].ix);
      chk_eq("hold_bin", peak_bin, sb[0].bn);
    end
    if (rst) begin
      busy_exp = 0; wait_flag = 0; out_flag = 0; res_pending = 0;
      xfer_cnt = 0; res_frame = 0; aborted = 1; sb.delete();
      return;
    end
    was_busy = busy_exp;
    if (am_tvalid && am_tready) begin
      exp_last = ((xfer_cnt % FL) == FL - 1);
      chk_eq("tlast", am_tlast, exp_last);
      chk_eq("xi_pass", am_xi, s_axis_xi);
      chk_eq("xq_pass", am_xq, s_axis_xq);
      xfer_cnt++;
      if (rst_after != 0 && xfer_cnt == rst_after) rst_req = 1'b1;
      if (exp_last) begin
        wait_flag = 1; res_pending = 1; res_wait = res_delay;
      end
    end
    if (am_res_tvalid && am_res_tready) begin
      res_pending = 0; wait_flag = 0; res_frame++;
      if (res_frame == NB) out_flag = 1;
    end
    if (m_axis_tvalid && m_axis_tready) begin
      chk_eq("sb_nonempty", sb.size(), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk_eq("peak_max", peak_max, e.mx);
        chk_eq("peak_index", peak_index, e.ix);
        chk_eq("peak_bin", peak_bin, e.bn);
        last_exp = e;
      end
      chk_eq("xfers", xfer_cnt, NB * FL);
      out_flag = 0; busy_exp = 0; done_cnt++;
    end
    if (start && !was_busy) begin
      busy_exp = 1; xfer_cnt = 0; res_frame = 0;
      sb.push_back(golden());
    end
    if (poke_start && out_flag && hold_cnt == 5) begin
      start_req = 1'b1; poke_start = 0;
    end
  endtask

  task automatic run_search(input int delay, input bit rnd, input int hold, input bit poke,
                            input int rst_at);
    int d0;
    d0 = done_cnt;
    res_delay = delay; rnd_ready = rnd; hold_cnt = hold; poke_start = poke;
    rst_after = rst_at; aborted = 0;
    start_req = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (done_cnt != d0 || aborted) break;
    end
    if (!aborted) chk_eq("search_done", done_cnt - d0, 1);
    rst_after = 0; rnd_ready = 0;
    step();
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_axis_tvalid = 1'b0; s_axis_xi = '0; s_axis_xq = '0;
    am_tready = 1'b1; am_res_tvalid = 1'b0; am_res_max = '0; am_res_index = '0;
    m_axis_tready = 1'b1;
    d1_start = 1'b0; d1_s_tvalid = 1'b0; d1_s_xi = '0; d1_s_xq = '0; d1_am_tready = 1'b1;
    d1_res_tvalid = 1'b0; d1_res_max = '0; d1_res_index = '0; d1_m_tready = 1'b1;
    start_req = 0; rst_req = 0; rnd_ready = 0; poke_start = 0;
    busy_exp = 0; wait_flag = 0; out_flag = 0; res_pending = 0; aborted = 0;
    res_wait = 0; res_delay = 0; res_frame = 0; hold_cnt = 0; xfer_cnt = 0;
    rst_after = 0; done_cnt = 0;

    repeat (3) @(posedge clk);
    rst_req = 1'b1;
    step();
    chk_eq("rst_peak_max", peak_max, 0);
    chk_eq("rst_peak_index", peak_index, 0);
    chk_eq("rst_peak_bin", peak_bin, 0);
    chk_eq("rst_tlast", am_tlast, 0);
    chk_eq("rst_tready", s_axis_tready, 0);

    // Directed tables: tie at 50 keeps bin 1.
    tab_max = '{25'd10, 25'd50, 25'd30, 25'd50};
    tab_idx = '{8'd2, 8'd5, 8'd7, 8'd1};
    run_search(0, 0, 0, 0, 0);
    chk_eq("dir_max", last_exp.mx, 50);
    chk_eq("dir_index", last_exp.ix, 5);
    chk_eq("dir_bin", last_exp.bn, 1);

    // Random ready, delayed results, downstream stall with an ignored start.
    for (int b = 0; b < NB; b++) begin
      tab_max[b] = 25'($urandom_range(0, 40));
      tab_idx[b] = 8'($urandom_range(0, FL - 1));
    end
    tab_max[3] = tab_max[1];
    run_search(5, 1, 10, 1, 0);
    chk_eq("keep_max", peak_max, last_exp.mx);
    chk_eq("keep_bin", peak_bin, last_exp.bn);

    // Abort mid-frame, then a fresh search must restart its counters.
    run_search(0, 0, 0, 0, 13);
    step();
    chk_eq("abort_peak_max", peak_max, 0);
    chk_eq("abort_tlast", am_tlast, 0);
    for (int b = 0; b < NB; b++) begin
      tab_max[b] = 25'($urandom_range(1, 1000));
      tab_idx[b] = 8'($urandom_range(0, FL - 1));
    end
    run_search(2, 1, 0, 0, 0);

    // num_bins=1, frame_len=1 instance.
    @(negedge clk); d1_start = 1'b1;
    #1 chk_eq("d1_busy0", d1_busy, 0);
    @(negedge clk); d1_start = 1'b0; d1_s_tvalid = 1'b1; d1_s_xi = 12'd5;
    #1 chk_eq("d1_am_tvalid", d1_am_tvalid, 1);
    chk_eq("d1_tlast", d1_am_tlast, 1);
    chk_eq("d1_xi", d1_am_xi, 5);
    @(negedge clk); d1_s_tvalid = 1'b0;
    d1_res_tvalid = 1'b1; d1_res_max = 25'd7; d1_res_index = 8'd0;
    #1 chk_eq("d1_res_tready", d1_res_tready, 1);
    chk_eq("d1_s_tready", d1_s_tready, 0);
    @(negedge clk); d1_res_tvalid = 1'b0; d1_res_max = 25'd0;
    #1 chk_eq("d1_m_tvalid", d1_m_tvalid, 1);
    chk_eq("d1_peak_max", d1_peak_max, 7);
    chk_eq("d1_peak_index", d1_peak_index, 0);
    chk_eq("d1_peak_bin", d1_peak_bin, 0);
    @(negedge clk);
    #1 chk_eq("d1_m_tvalid_done", d1_m_tvalid, 0);
    chk_eq("d1_busy_done", d1_busy, 0);
    chk_eq("d1_keep_max", d1_peak_max, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
